// File: rtl/apb_mst_pkg.sv
// Shared types and default widths for the APB4 requester bridge.
package apb_mst_pkg;

   localparam int unsigned APB_MST_AW = 32;
   localparam int unsigned APB_MST_DW = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_mst_state_e;

   typedef struct packed {
      logic                      write;
      logic [APB_MST_AW-1:0]     addr;
      logic [APB_MST_DW-1:0]     wdata;
      logic [APB_MST_DW/8-1:0]   strb;
   } apb_mst_cmd_t;

   typedef struct packed {
      logic [APB_MST_DW-1:0]     rdata;
      logic                      err;
   } apb_mst_rsp_t;

endpackage

// File: rtl/apb_mst_timer.sv
// ACCESS-phase wait counter; expired flags the edge on which the count reaches LIMIT.
module apb_mst_timer #(
   parameter int unsigned LIMIT = 16
) (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   // Combinational look-ahead so the FSM leaves ACCESS on the LIMIT-th stalled cycle.
   assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_mst_bridge.sv
// APB4 requester: valid/ready command port in, SETUP/ACCESS on the bus, valid/ready response out.
// Optional ACCESS timeout (adds rsp_timeout) enabled by defining APB_MST_TIMEOUT_EN.
module apb_mst_bridge
   import apb_mst_pkg::*;
#(
   parameter int unsigned AW             = APB_MST_AW,
   parameter int unsigned DW             = APB_MST_DW,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   input  logic [DW/8-1:0] cmd_strb,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
`ifdef APB_MST_TIMEOUT_EN
   output logic          rsp_timeout,
`endif
   output logic          PSEL,
   output logic          PENABLE,
   output logic          PWRITE,
   output logic [AW-1:0] PADDR,
   output logic [DW-1:0] PWDATA,
   output logic [DW/8-1:0] PSTRB,
   input  logic          PREADY,
   input  logic          PSLVERR,
   input  logic [DW-1:0] PRDATA
);

   if (!(DW == 8 || DW == 16 || DW == 32) || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("apb_mst_bridge: DW must be 8, 16 or 32 and TIMEOUT_CYCLES at least 1");
   end

   apb_mst_state_e state;
   logic           tmo_expired;

`ifdef APB_MST_TIMEOUT_EN
   apb_mst_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .clear   (state == SETUP),
      .enable  ((state == ACCESS) && !PREADY),
      .expired (tmo_expired)
   );
`else
   assign tmo_expired = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= IDLE;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         PSTRB     <= '0;
`ifdef APB_MST_TIMEOUT_EN
         rsp_timeout <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
               // The bus registers double as the command capture; they hold after completion.
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  PSEL      <= 1'b1;
                  PWRITE    <= cmd_write;
                  PADDR     <= cmd_addr;
                  PWDATA    <= cmd_write ? cmd_wdata : '0;
                  PSTRB     <= cmd_write ? cmd_strb  : '0;
                  state     <= SETUP;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (PREADY) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
                  rsp_err   <= PSLVERR;
                  state     <= RESP;
               end else if (tmo_expired) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
`ifdef APB_MST_TIMEOUT_EN
                  rsp_timeout <= 1'b1;
`endif
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
`ifdef APB_MST_TIMEOUT_EN
                  rsp_timeout <= 1'b0;
`endif
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_mst_bridge.sv
// Directed bench for apb_mst_bridge: vector table plus reset, back-to-back and timeout sequences.
module tb_apb_mst_bridge;

`ifdef APB_MST_TIMEOUT_EN
   localparam int unsigned TMO = 4;
`else
   localparam int unsigned TMO = 16;
`endif

   logic        PCLK;
   logic        PRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
`ifdef APB_MST_TIMEOUT_EN
   logic        rsp_timeout;
`endif
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic        PREADY;
   logic        PSLVERR;
   logic [31:0] PRDATA;

   apb_mst_bridge #(
      .AW             (32),
      .DW             (32),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_strb  (cmd_strb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
`ifdef APB_MST_TIMEOUT_EN
      .rsp_timeout (rsp_timeout),
`endif
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PSTRB     (PSTRB),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR),
      .PRDATA    (PRDATA)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int unsigned waits;
      logic [31:0] prdata;
      logic        slverr;
      int unsigned hold;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[4];
   int   n_chk;
   int   n_fail;

   // Back-to-back expectations, sampled after each edge starting at the first accept.
   int exp_psel [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
   int exp_pen  [8] = '{0, 1, 0, 0, 0, 1, 0, 0};
   int exp_rdy  [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
   int exp_rv   [8] = '{0, 0, 1, 0, 0, 0, 1, 0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic wait_ready();
      int unsigned t;
      t = 0;
      while (cmd_ready !== 1'b1 && t < 50) begin
         tick();
         t++;
      end
      chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_strb  = v.strb;
      tick();
      cmd_valid = 1'b0;
      cmd_addr  = ~v.addr;
      cmd_wdata = ~v.wdata;
      chk("setup_psel",      {31'd0, PSEL},      32'd1);
      chk("setup_penable",   {31'd0, PENABLE},   32'd0);
      chk("setup_paddr",     PADDR,              v.addr);
      chk("setup_pwrite",    {31'd0, PWRITE},    {31'd0, v.write});
      chk("setup_pwdata",    PWDATA,             v.write ? v.wdata : 32'd0);
      chk("setup_pstrb",     {28'd0, PSTRB},     v.write ? {28'd0, v.strb} : 32'd0);
      chk("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
      for (int unsigned w = 0; w <= v.waits; w++) begin
         chk("access_sel_en",  {30'd0, PSEL, PENABLE}, 32'd3);
         chk("access_paddr",   PADDR,                  v.addr);
         chk("access_pwdata",  PWDATA,                 v.write ? v.wdata : 32'd0);
         chk("access_rsp_vld", {31'd0, rsp_valid},     32'd0);
         PREADY  = (w == v.waits);
         PSLVERR = (w == v.waits) ? v.slverr : 1'b1;
         PRDATA  = (w == v.waits) ? v.prdata : 32'hFFFF_FFFF;
         tick();
      end
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = 32'h0;
      chk("resp_sel_en", {30'd0, PSEL, PENABLE}, 32'd0);
      chk("resp_valid",  {31'd0, rsp_valid},     32'd1);
      chk("resp_rdata",  rsp_rdata,              v.exp_rdata);
      chk("resp_err",    {31'd0, rsp_err},       {31'd0, v.exp_err});
      for (int unsigned h = 0; h < v.hold; h++) begin
         tick();
         chk("hold_valid",     {31'd0, rsp_valid}, 32'd1);
         chk("hold_rdata",     rsp_rdata,          v.exp_rdata);
         chk("hold_err",       {31'd0, rsp_err},   {31'd0, v.exp_err});
         chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("done_valid",     {31'd0, rsp_valid}, 32'd0);
      chk("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("done_psel",      {31'd0, PSEL},      32'd0);
      chk("done_paddr_kept", PADDR,             v.addr);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_psel"},      {31'd0, PSEL},      32'd0);
      chk({tag, "_penable"},   {31'd0, PENABLE},   32'd0);
      chk({tag, "_pwrite"},    {31'd0, PWRITE},    32'd0);
      chk({tag, "_paddr"},     PADDR,              32'd0);
      chk({tag, "_pwdata"},    PWDATA,             32'd0);
      chk({tag, "_pstrb"},     {28'd0, PSTRB},     32'd0);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata,          32'd0);
      chk({tag, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
      chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      n_chk  = 0;
      n_fail = 0;
      //          wr    addr         wdata          strb  w  prdata         err  hold exp_rdata      exp_err
      vecs[0] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'hCAFE_F00D, 1'b0, 0, 32'h0,         1'b0};
      vecs[1] = '{1'b0, 32'h20, 32'h5555_5555, 4'hF, 3, 32'h1234_5678, 1'b0, 0, 32'h1234_5678, 1'b0};
      vecs[2] = '{1'b1, 32'h30, 32'h0000_AA55, 4'h3, 0, 32'h7777_7777, 1'b1, 5, 32'h0,         1'b1};
      vecs[3] = '{1'b0, 32'h44, 32'h0,         4'h0, 1, 32'h0BAD_F00D, 1'b1, 0, 32'h0BAD_F00D, 1'b1};

      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0;
      cmd_wdata = 32'h0;
      cmd_strb  = 4'h0;
      rsp_ready = 1'b0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      PRDATA    = 32'h0;

      #12;
      chk_all_zero("reset");
      PRESETn = 1'b1;
      #1;
      chk("pre_edge_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
      chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Reset asserted in the ACCESS phase of a read: outputs clear without a clock edge.
      wait_ready();
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h80;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      chk("pre_rst_access", {30'd0, PSEL, PENABLE}, 32'd3);
      #2;
      PRESETn = 1'b0;
      #1;
      chk_all_zero("async_rst");
      tick();
      chk("in_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      PRESETn = 1'b1;
      tick();
      chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      rv = '{1'b0, 32'h04, 32'h0, 4'h0, 0, 32'hA5A5_0404, 1'b0, 0, 32'hA5A5_0404, 1'b0};
      run_vec(rv);

      // Back-to-back with cmd_valid held and PREADY/rsp_ready permanently high.
      wait_ready();
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h100;
      cmd_wdata = 32'h1;
      cmd_strb  = 4'hF;
      PREADY    = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("b2b_psel",      {31'd0, PSEL},      exp_psel[i]);
         chk("b2b_penable",   {31'd0, PENABLE},   exp_pen[i]);
         chk("b2b_cmd_ready", {31'd0, cmd_ready}, exp_rdy[i]);
         chk("b2b_rsp_valid", {31'd0, rsp_valid}, exp_rv[i]);
         chk("b2b_idle_psel", {31'd0, PSEL & cmd_ready}, 32'd0);
         if (i == 0) cmd_addr = 32'h200;
         if (i == 4) begin
            chk("b2b_second_paddr", PADDR, 32'h200);
            cmd_valid = 1'b0;
         end
      end
      PREADY    = 1'b0;
      rsp_ready = 1'b0;

`ifdef APB_MST_TIMEOUT_EN
      // Slave never responds: four ACCESS cycles, then an error response with zero data.
      wait_ready();
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h60;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("tmo_access",    {30'd0, PSEL, PENABLE}, 32'd3);
         chk("tmo_rsp_valid", {31'd0, rsp_valid},     32'd0);
      end
      tick();
      chk("tmo_sel_en",  {30'd0, PSEL, PENABLE}, 32'd0);
      chk("tmo_valid",   {31'd0, rsp_valid},     32'd1);
      chk("tmo_err",     {31'd0, rsp_err},       32'd1);
      chk("tmo_flag",    {31'd0, rsp_timeout},   32'd1);
      chk("tmo_rdata",   rsp_rdata,              32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("tmo_flag_clr", {31'd0, rsp_timeout}, 32'd0);
      chk("tmo_done",     {31'd0, cmd_ready},   32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_mst_bridge.md
Name: apb_mst_bridge

Overview:
- APB4 requester (master) that drives the PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB bus seen by the APB slave and its interface.
- Converts a single-outstanding valid/ready command port into APB SETUP/ACCESS phases.
- Returns read data and error status on a valid/ready response port.
- Sits between the test or system-side command source and the APB slave under test.

Parameters:
- AW, 32, address width; PADDR and cmd_addr width.
- DW, 32, data width; must be 8, 16 or 32. PSTRB width is DW/8.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for PREADY (used only with the optional feature).

Ports:
- PCLK  input  1  APB clock; all logic on rising edge.
- PRESETn  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  bridge can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  AW  target address.
- cmd_wdata  input  DW  write data.
- cmd_strb  input  DW/8  write byte strobes.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  DW  read data; 0 for writes.
- rsp_err  output  1  PSLVERR captured, or timeout when the feature is enabled.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  AW  APB address.
- PWDATA  output  DW  APB write data.
- PSTRB  output  DW/8  APB strobes.
- PREADY  input  1  slave ready.
- PSLVERR  input  1  slave error.
- PRDATA  input  DW  slave read data.

Behaviour:
Clocking and reset
- One clock (PCLK); asynchronous active-low reset (PRESETn).
- On PRESETn=0, immediately and regardless of state: all outputs 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err); cmd_ready=0; FSM to IDLE.
- Reset mid-transfer aborts the transfer with no response.
- cmd_ready rises the first edge after PRESETn deasserts.

FSM
- States: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1; PSEL=0; PENABLE=0.
  - On cmd_valid&cmd_ready: capture command, go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL=1, PENABLE=0; PADDR/PWRITE/PWDATA/PSTRB driven from the captured command.
  - PSTRB forced to 0 on reads. PWDATA is 0 on reads.
  - Go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; all address/control/data held stable from SETUP.
  - Stay while PREADY=0 at the clock edge.
  - On PREADY=1: capture PRDATA (reads only; writes give rsp_rdata=0) and PSLVERR into rsp_*; PSEL=0, PENABLE=0; go to RESP.
- RESP:
  - rsp_valid=1 with rsp_rdata/rsp_err held until rsp_ready=1, then IDLE.
  - PSEL=0 throughout.

Timing and ordering
- Latency: accept at edge N; SETUP visible after N; ACCESS after N+1; PREADY=1 sampled at N+2 gives rsp_valid after N+2. Each wait state adds 1 cycle.
- Next command is accepted no earlier than the cycle after the response handshake, so there is at most one outstanding transfer.
- cmd_ready is 0 in every state except IDLE. cmd_* changes outside the handshake are ignored.
- PADDR/PWRITE/PWDATA/PSTRB keep their last values when idle. Only PSEL/PENABLE return to 0.
- PSLVERR is sampled only when PSEL&PENABLE&PREADY; ignored otherwise.
- rsp_ready asserted outside RESP has no effect.

Optional Feature:
- Macro: APB_MST_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to ACCESS; increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0: drop PSEL/PENABLE; go to RESP with rsp_err=1, rsp_rdata=0; pulse output rsp_timeout (1 bit, present only under the macro) while in that RESP.
  - PREADY=1 on the same edge the count reaches TIMEOUT_CYCLES: normal completion wins.
- Undefined: no counter, no rsp_timeout port; ACCESS waits indefinitely.

Decomposition:
- Package apb_mst_pkg holds:
  - state enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP};
  - packed struct apb_mst_cmd_t {write, addr, wdata, strb};
  - packed struct apb_mst_rsp_t {rdata, err};
  - default AW/DW localparams.
- One natural sub-module: apb_mst_timer, the timeout counter with clear/enable/expired ports. It is instantiated only under APB_MST_TIMEOUT_EN.

Test Plan:
- Write 0xDEADBEEF to 0x10 with strb 0xF, PREADY=1 immediately: PSEL 2 cycles, PENABLE 1 cycle, PWDATA=0xDEADBEEF, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read 0x20 with 3 wait states, slave returns 0x12345678: ACCESS lasts 4 cycles with PADDR stable; PSTRB=0; rsp_rdata=0x12345678.
- Write 0xAA55 with strb 0x3 and PSLVERR=1 with PREADY: rsp_err=1. Hold rsp_ready=0 for 5 cycles: rsp_valid and data held; cmd_ready stays 0 until the cycle after the handshake.
- Assert PRESETn=0 in ACCESS of a read: all outputs 0 without waiting for a clock edge; after release, cmd_ready=1 and a new read to 0x04 completes normally.
- Two back-to-back commands with cmd_valid held high: second SETUP starts 1 cycle after the first response handshake; PSEL is never 1 in IDLE.
- (APB_MST_TIMEOUT_EN, TIMEOUT_CYCLES=4) PREADY held 0: PSEL drops after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
